// File: rtl/router_scheduler_if.sv
// Handshake bundle between the scheduler, its requesters and the shared router.
// master: scheduler side (drives grants, router trigger, completion report).
// slave: environment side (drives jobs and router status).
interface router_scheduler_if #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 5,
  parameter int IdWidth   = 2,
  parameter int CntWidth  = 6
);
  logic [NumReq-1:0]           reqValid;
  logic [NumReq-1:0]           reqReady;
  logic [NumReq*AddrWidth-1:0] reqStartAddr;
  logic [NumReq*AddrWidth-1:0] reqFinalAddr;
  logic                        routeEn;
  logic [AddrWidth-1:0]        routeStartAddr;
  logic [AddrWidth-1:0]        routeFinalAddr;
  logic                        routeFinished;
  logic                        routeRoutingOutput;
  logic                        doneValid;
  logic [IdWidth-1:0]          doneId;
  logic [1:0]                  doneErr;
  logic [CntWidth-1:0]         doneVecCount;
  logic                        busy;

  modport master (
    input  reqValid, reqStartAddr, reqFinalAddr, routeFinished, routeRoutingOutput,
    output reqReady, routeEn, routeStartAddr, routeFinalAddr,
           doneValid, doneId, doneErr, doneVecCount, busy
  );

  modport slave (
    output reqValid, reqStartAddr, reqFinalAddr, routeFinished, routeRoutingOutput,
    input  reqReady, routeEn, routeStartAddr, routeFinalAddr,
           doneValid, doneId, doneErr, doneVecCount, busy
  );
endinterface

// File: rtl/router_scheduler.sv
// Round-robin scheduler sharing one router among NumReq requesters; reports per-job completion.
// Latency: grant in IDLE, routeEn the cycle after accept, report one cycle after router finished edge.
// Backpressure: only one job in flight; reqReady is offered only in IDLE, to a single requester.
// Optional WAIT watchdog enabled by macro ROUTER_SCHED_TIMEOUT_EN.
module router_scheduler #(
  parameter int NumReq        = 4,
  parameter int Depth         = 32,
  parameter int AddrWidth     = $clog2(Depth),
  parameter int IdWidth       = $clog2(NumReq),
  parameter int CntWidth      = AddrWidth + 1,
  parameter int TimeoutCycles = 1024
) (
  input logic               clk,
  input logic               rst,
  router_scheduler_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  logic [1:0]           state;
  logic [IdWidth-1:0]   rr_ptr;
  logic [IdWidth-1:0]   grant;
  logic [IdWidth-1:0]   cand;
  logic                 grant_found;
  logic [AddrWidth-1:0] grant_start;
  logic [AddrWidth-1:0] grant_final;
  logic [IdWidth-1:0]   job_id;
  logic [AddrWidth-1:0] start_q;
  logic [AddrWidth-1:0] final_q;
  logic [CntWidth-1:0]  vec_cnt;
  logic [1:0]           err_q;
  logic                 finished_q;
  logic                 routing_q;
  logic                 finished_rise;
  logic                 routing_rise;
  logic                 take;
  logic                 timeout_hit;

  // Round-robin search from rr_ptr upward with wrap, plus address mux for the winner
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = rr_ptr;
    grant_start = '0;
    grant_final = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (!grant_found && bus.reqValid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
      cand = (cand == IdWidth'(NumReq - 1)) ? '0 : cand + 1'b1;
    end
    for (int i = 0; i < NumReq; i++) begin
      if (grant == IdWidth'(i)) begin
        grant_start = bus.reqStartAddr[i*AddrWidth +: AddrWidth];
        grant_final = bus.reqFinalAddr[i*AddrWidth +: AddrWidth];
      end
    end
  end

  // Accept only in IDLE; reset forces the grant off even though the FSM already reads IDLE
  assign take = (state == IDLE) && grant_found && !rst;

  // One-hot ready toward the granted requester
  always_comb begin
    bus.reqReady = '0;
    if (take) bus.reqReady[grant] = 1'b1;
  end

  // Edge detectors on the router status levels (a stale finished level must not complete a job)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      finished_q <= 1'b0;
      routing_q  <= 1'b0;
    end else begin
      finished_q <= bus.routeFinished;
      routing_q  <= bus.routeRoutingOutput;
    end
  end

  assign finished_rise = bus.routeFinished & ~finished_q;
  assign routing_rise  = bus.routeRoutingOutput & ~routing_q;

`ifdef ROUTER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] wait_cnt;

  // WAIT-cycle watchdog, zero on entry to WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                    wait_cnt <= '0;
  end

  assign timeout_hit = (wait_cnt == TW'(TimeoutCycles - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
`endif

  // Job FSM: accept, trigger, track completion, report and advance the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      job_id  <= '0;
      start_q <= '0;
      final_q <= '0;
      vec_cnt <= '0;
      err_q   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            job_id  <= grant;
            start_q <= grant_start;
            final_q <= grant_final;
            vec_cnt <= '0;
            if (grant_final < grant_start) begin
              err_q <= ERR_RANGE;
              state <= REPORT;
            end else begin
              err_q <= ERR_OK;
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // A vector edge coinciding with the finished edge still lands in this report
          if (routing_rise && (vec_cnt != '1)) vec_cnt <= vec_cnt + 1'b1;
          if (finished_rise) begin
            err_q <= ERR_OK;
            state <= REPORT;
          end else if (timeout_hit) begin
            err_q <= ERR_TIMEOUT;
            state <= REPORT;
          end
        end
        REPORT: begin
          rr_ptr <= (job_id == IdWidth'(NumReq - 1)) ? '0 : job_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.routeEn        = (state == ISSUE);
  assign bus.routeStartAddr = start_q;
  assign bus.routeFinalAddr = final_q;
  assign bus.doneValid      = (state == REPORT);
  assign bus.doneId         = job_id;
  assign bus.doneErr        = err_q;
  assign bus.doneVecCount   = vec_cnt;
  assign bus.busy           = (state != IDLE);

endmodule

// File: doc/router_scheduler.md
Name: router_scheduler

Overview:
Shares one router instance among NumReq requesters (PE-array loaders). Each requester submits a route job, a start/final address pair in the activation/weight buffer. A round-robin arbiter picks one job and range-checks it. The scheduler then triggers the router, tracks the job to completion and returns a per-job completion report with the number of routed output vectors.

Parameters:
NumReq, 4, number of requesters
Depth, 32, buffer depth seen by the router
AddrWidth, $clog2(Depth), buffer address width
IdWidth, $clog2(NumReq), requester index width
CntWidth, AddrWidth+1, routed-vector counter width
TimeoutCycles, 1024, WAIT watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
reqValid  in  NumReq  per-requester job valid
reqReady  out  NumReq  per-requester job accept (one-hot or zero)
reqStartAddr  in  NumReq*AddrWidth  packed start addresses, requester i at bits [(i+1)*AddrWidth-1 -: AddrWidth]
reqFinalAddr  in  NumReq*AddrWidth  packed final addresses, same packing
routeEn  out  1  router start pulse
routeStartAddr  out  AddrWidth  job start address to router
routeFinalAddr  out  AddrWidth  job final address to router
routeFinished  in  1  router finished level
routeRoutingOutput  in  1  router output-valid level
doneValid  out  1  one-cycle completion report
doneId  out  IdWidth  requester of the reported job
doneErr  out  2  00 ok, 01 bad range, 10 timeout
doneVecCount  out  CntWidth  routed vectors in the reported job
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: reqReady=0, routeEn=0, routeStartAddr=0, routeFinalAddr=0, doneValid=0, doneId=0, doneErr=0, doneVecCount=0, busy=0.
- Reset also clears: RR pointer=0, vector counter=0, edge-detect flops=0, FSM=IDLE.
- Reset mid-job aborts the job with no done report. The router shares rst.
- States: IDLE, ISSUE, WAIT, REPORT.
- IDLE arbitration:
  - Grant = first i with reqValid[i], searching from RR pointer upward with wrap.
  - reqReady[grant]=1 combinationally in IDLE only; all other reqReady bits are 0.
  - On handshake: latch addresses and grant ID; clear the vector counter.
  - finalAddr < startAddr: go to REPORT with err=01; routeEn is never asserted.
  - Otherwise: go to ISSUE.
- ISSUE: routeEn=1 for exactly one cycle, then WAIT.
- routeStartAddr/routeFinalAddr: registered, and held stable from ISSUE until the next accepted job. The router samples startAddr one cycle after routeEn and samples finalAddr repeatedly during the job.
- WAIT:
  - Count rising edges of routeRoutingOutput (saturate at all-ones).
  - Leave on a rising edge of routeFinished (finished & ~finished_q) and go to REPORT with err=00.
  - A finished level held high from the previous job is not completion. Only a fresh edge counts; the router clears finished two cycles after routeEn.
  - Rising edges of routingOutput and finished in the same cycle: the vector edge is counted and is included in the report.
- REPORT:
  - doneValid=1 for one cycle with doneId, doneErr, doneVecCount.
  - RR pointer = grant+1, wrapping to 0 after NumReq-1. Applies to errored jobs too.
  - Return to IDLE.
- Minimum job-to-job spacing: REPORT then IDLE, so a new handshake is possible one cycle after doneValid.
- Requester holds reqValid and its addresses until reqReady. Dropping reqValid early is legal; that requester is simply not granted.

Optional Feature:
Macro ROUTER_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter starts at 0 on entry to WAIT.
  - Reaching TimeoutCycles-1 with no finished edge: go to REPORT with err=10 and the current vector count.
  - The router may still be active after a timeout; recovery is by rst.
- Undefined: no counter; WAIT waits indefinitely; doneErr[1] is constant 0.

Test Plan:
1. Use a behavioural router model that pulses routingOutput 3 times and then raises finished. reqValid[0]=1 with start=4, final=12 -> reqReady[0] for 1 cycle; routeEn 1-cycle pulse; routeStartAddr=4 and routeFinalAddr=12 held; then doneValid with doneId=0, doneErr=00, doneVecCount=3.
2. All four reqValid high after reset -> grants in order 0,1,2,3. Then re-raise only req1 and req3 -> grants 1 then 3. Exactly one reqReady bit is high per grant.
3. req2 with start=10, final=5 -> reqReady[2]; no routeEn; the next cycle is REPORT with doneValid, doneId=2, doneErr=01, doneVecCount=0; the RR pointer advances to 3.
4. Model holds finished=1 from the prior job, drops it 2 cycles after routeEn and raises it 20 cycles later -> doneValid appears only after that rise, not during the stale high.
5. Assert rst during WAIT -> all outputs take their reset values immediately. After rst is released, a new req1 job completes normally with the grant search starting from requester 0.
6. With ROUTER_SCHED_TIMEOUT_EN and TimeoutCycles=16, the model never finishes -> doneValid with doneErr=10 sixteen cycles after entering WAIT. Without the macro, no doneValid occurs within 2000 cycles.
